// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: round-robin arbiter serialising two requesters' commands onto a shared JK flip-flop bank
module jk_bank_arbiter #(
   parameter int WIDTH = 4,
   parameter int IDX_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic [1:0]       op0,
   input  logic [IDX_W-1:0] idx0,
   input  logic             req1,
   input  logic [1:0]       op1,
   input  logic [IDX_W-1:0] idx1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             done,
   output logic             busy,
   output logic [WIDTH-1:0] q
);
   typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;
   state_t state_q, state_d;
   logic ptr_q, ptr_d, win1;
   logic [1:0] op_q, op_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic gnt0_q, gnt0_d, gnt1_q, gnt1_d, done_q, done_d;
   logic [WIDTH-1:0] q_q, q_d, j, k;

   // Next state: arbitrate in IDLE, drive the selected bit's j/k only during APPLY
   always_comb begin
      state_d = state_q;
      ptr_d = ptr_q;
      op_d = op_q;
      idx_d = idx_q;
      gnt0_d = 1'b0;
      gnt1_d = 1'b0;
      done_d = 1'b0;
      j = '0;
      k = '0;
      win1 = req1 & (~req0 | ptr_q);
      case (state_q)
         IDLE: if (req0 | req1) begin
            op_d = win1 ? op1 : op0;
            idx_d = win1 ? idx1 : idx0;
            gnt0_d = ~win1;
            gnt1_d = win1;
            ptr_d = ~win1;
            state_d = APPLY;
         end
         APPLY: begin
            j[idx_q] = op_q[1];
            k[idx_q] = op_q[0];
            done_d = 1'b1;
            state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
      q_d = (j & ~q_q) | (~k & q_q);
   end

   // State, latched command, pulses and bank; reset aborts any command in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q <= 1'b0;
         op_q <= '0;
         idx_q <= '0;
         gnt0_q <= 1'b0;
         gnt1_q <= 1'b0;
         done_q <= 1'b0;
         q_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q <= ptr_d;
         op_q <= op_d;
         idx_q <= idx_d;
         gnt0_q <= gnt0_d;
         gnt1_q <= gnt1_d;
         done_q <= done_d;
         q_q <= q_d;
      end
   end

   assign gnt0 = gnt0_q;
   assign gnt1 = gnt1_q;
   assign done = done_q;
   assign busy = state_q != IDLE;
   assign q = q_q;
endmodule
